// File: rtl/video_pkg.sv
// Shared video definitions: pixel layout, luma weights and
// default dark-mode thresholds.
package video_pkg;

    localparam int PIX_W      = 24;
    localparam int R_LSB      = 16;
    localparam int G_LSB      = 8;
    localparam int B_LSB      = 0;

    // Y = (2R + 5G + B) >> 3, held in an 11-bit intermediate
    localparam int COEF_R     = 2;
    localparam int COEF_G     = 5;
    localparam int COEF_B     = 1;
    localparam int LUMA_SHIFT = 3;
    localparam int LUMA_ACC_W = 11;

    localparam logic [7:0] TH_HI_DEF = 8'd160;
    localparam logic [7:0] TH_LO_DEF = 8'd96;

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic [PIX_W-1:0] data;
    } vid_t;

endpackage

// File: rtl/luma_calc.sv
// Combinational RGB888 to 8-bit luma approximation.
// Maximum input (all 0xFF) yields exactly 255.
module luma_calc
    import video_pkg::*;
(
    input  logic [PIX_W-1:0] rgb,
    output logic [7:0]       y
);

    logic [LUMA_ACC_W-1:0] r;
    logic [LUMA_ACC_W-1:0] g;
    logic [LUMA_ACC_W-1:0] b;
    logic [LUMA_ACC_W-1:0] acc;

    assign r = LUMA_ACC_W'(rgb[R_LSB +: 8]);
    assign g = LUMA_ACC_W'(rgb[G_LSB +: 8]);
    assign b = LUMA_ACC_W'(rgb[B_LSB +: 8]);

    assign acc = LUMA_ACC_W'(COEF_R) * r
               + LUMA_ACC_W'(COEF_G) * g
               + LUMA_ACC_W'(COEF_B) * b;

    assign y = acc[LUMA_SHIFT +: 8];

endmodule

// File: rtl/dark_mode_filter.sv
// Two-stage pass-through that inverts active pixels when the
// previous frame's mean luma was bright, with hysteresis.
module dark_mode_filter
    import video_pkg::*;
#(
    parameter logic [7:0] TH_HI     = TH_HI_DEF,
    parameter logic [7:0] TH_LO     = TH_LO_DEF,
    parameter logic       VS_ACTIVE = 1'b1,
    parameter int         CNT_W     = 22,
    parameter int         SUM_W     = 30
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             vin_hs_i,
    input  logic             vin_vs_i,
    input  logic             vin_de_i,
    input  logic [PIX_W-1:0] vin_data_i,
    output logic             vout_hs_o,
    output logic             vout_vs_o,
    output logic             vout_de_o,
    output logic [PIX_W-1:0] vout_data_o,
    output logic             invert_o,
    output logic [CNT_W-1:0] frame_pixels_o
);

    localparam int PRD_W = CNT_W + 8;
    localparam int CMP_W = (SUM_W > PRD_W) ? SUM_W : PRD_W;

    vid_t             s1;
    vid_t             s2;
    logic             vs_hist;
    logic [7:0]       y;
    logic             boundary;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W:0]   sum_add;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [SUM_W-1:0] snap_sum;
    logic [CNT_W-1:0] snap_cnt;
    logic [CNT_W-1:0] frame_pixels;

    logic             en_q;
    logic             dec_pend;
    logic             cmp_pend;
    logic             hi_q;
    logic             lo_q;
    logic             zero_q;
    logic             inv;
    logic [PRD_W-1:0] prod_hi;
    logic [PRD_W-1:0] prod_lo;

    luma_calc u_luma (
        .rgb (s1.data),
        .y   (y)
    );

    // Stage 1: register the raw input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1      <= '0;
            vs_hist <= ~VS_ACTIVE;
        end else begin
            s1.hs   <= vin_hs_i;
            s1.vs   <= vin_vs_i;
            s1.de   <= vin_de_i;
            s1.data <= vin_data_i;
            vs_hist <= s1.vs;
        end
    end

    // Stage 2: blanking data is never inverted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2 <= '0;
        end else begin
            s2.hs   <= s1.hs;
            s2.vs   <= s1.vs;
            s2.de   <= s1.de;
            s2.data <= (inv && s1.de) ? ~s1.data : s1.data;
        end
    end

    assign boundary = (s1.vs == VS_ACTIVE) &&
                      (vs_hist != VS_ACTIVE);

    assign sum_add = {1'b0, sum} + (SUM_W+1)'(y);

    always_comb begin
        sum_next = sum_add[SUM_W-1:0];
        cnt_next = cnt + 1'b1;
        if (sum_add[SUM_W]) begin
            sum_next = '1;
        end
        if (&cnt) begin
            cnt_next = cnt;
        end
    end

    // A pixel on the boundary cycle opens the new frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum          <= '0;
            cnt          <= '0;
            snap_sum     <= '0;
            snap_cnt     <= '0;
            frame_pixels <= '0;
            en_q         <= 1'b0;
            dec_pend     <= 1'b0;
        end else begin
            dec_pend <= boundary;
            if (boundary) begin
                snap_sum     <= sum;
                snap_cnt     <= cnt;
                frame_pixels <= cnt;
                en_q         <= enable_i;
                sum          <= s1.de ? SUM_W'(y) : '0;
                cnt          <= s1.de ? CNT_W'(1) : '0;
            end else if (s1.de) begin
                sum <= sum_next;
                cnt <= cnt_next;
            end
        end
    end

    assign prod_hi = PRD_W'(snap_cnt) * PRD_W'(TH_HI);
    assign prod_lo = PRD_W'(snap_cnt) * PRD_W'(TH_LO);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_pend <= 1'b0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            cmp_pend <= dec_pend;
            if (dec_pend) begin
                hi_q   <= CMP_W'(snap_sum) > CMP_W'(prod_hi);
                lo_q   <= CMP_W'(snap_sum) < CMP_W'(prod_lo);
                zero_q <= (snap_cnt == '0);
            end
        end
    end

    // Decision lands two cycles after the boundary
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv <= 1'b0;
        end else if (cmp_pend) begin
            if (!en_q) begin
                inv <= 1'b0;
            end else if (!zero_q) begin
                if (!inv && hi_q) begin
                    inv <= 1'b1;
                end else if (inv && lo_q) begin
                    inv <= 1'b0;
                end
            end
        end
    end

    assign vout_hs_o      = s2.hs;
    assign vout_vs_o      = s2.vs;
    assign vout_de_o      = s2.de;
    assign vout_data_o    = s2.data;
    assign invert_o       = inv;
    assign frame_pixels_o = frame_pixels;

endmodule
